uart_word_tx: RTL

//  Transmit half of the program-load UART link: serialises 32-bit words onto uart_txd as

---
 rtl/uart_word_tx_pkg.sv | 34 +++
 rtl/uart_tx_byte.sv | 131 +++++++++++++
 rtl/uart_word_tx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/uart_word_tx_pkg.sv
// uart_word_tx_pkg: shared types and helpers for the word-level UART transmitter.
//   tx_state_e   : per-byte 8N1 frame FSM states (IDLE/START/DATA/STOP)
//   word_state_e : word sequencer states
//   cycles_per_bit / cnt_width : baud divider and counter width helpers
package uart_word_tx_pkg;

   localparam int unsigned DATA_BITS      = 8;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned WORD_W         = DATA_BITS * BYTES_PER_WORD;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_SEND = 1'b1
   } word_state_e;

   // Clock cycles spent on each bit of the line.
   function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                  input int unsigned bit_rate);
      return clk_hz / bit_rate;
   endfunction

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: one-byte 8N1 serialiser.
//   clk, resetn   : clock, async active-low reset
//   byte_valid_i  : byte_data_i holds a byte to send
//   byte_data_i   : byte to send, captured when taken
//   byte_ready_c  : a byte is taken this cycle if byte_valid_i is high (combinational)
//   byte_done_c   : last cycle of the final stop bit (combinational)
//   txd_o         : serial line, registered, idle high
module uart_tx_byte
   import uart_word_tx_pkg::*;
#(
   parameter int unsigned CYCLES_PER_BIT = 5208,
   parameter int unsigned STOP_BITS      = 1
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 byte_valid_i,
   input  logic [DATA_BITS-1:0] byte_data_i,
   output logic                 byte_ready_c,
   output logic                 byte_done_c,
   output logic                 txd_o
);

   localparam int unsigned      CNT_W     = cnt_width(CYCLES_PER_BIT);
   localparam int unsigned      BIT_W     = 3;
   localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

   tx_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cyc_q, cyc_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 txd_q, txd_d;
   logic                 bit_end_c;

   assign bit_end_c = (cyc_q == CYC_LAST);

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= TX_IDLE;
         cyc_q   <= '0;
         bit_q   <= '0;
         data_q  <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         txd_q   <= txd_d;
      end
   end

   // Frame sequencing; bit_q counts data bits in DATA and stop bits in STOP.
   always_comb begin
      state_d      = state_q;
      cyc_d        = cyc_q;
      bit_d        = bit_q;
      data_d       = data_q;
      byte_ready_c = 1'b0;
      byte_done_c  = 1'b0;
      case (state_q)
         TX_IDLE: begin
            byte_ready_c = 1'b1;
            if (byte_valid_i) begin
               state_d = TX_START;
               cyc_d   = '0;
               bit_d   = '0;
               data_d  = byte_data_i;
            end
         end
         TX_START: begin
            if (bit_end_c) begin
               cyc_d   = '0;
               state_d = TX_DATA;
            end else begin
               cyc_d = cyc_q + CNT_W'(1);
            end
         end
         TX_DATA: begin
            if (bit_end_c) begin
               cyc_d = '0;
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
                  state_d = TX_STOP;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               cyc_d = cyc_q + CNT_W'(1);
            end
         end
         TX_STOP: begin
            if (bit_end_c) begin
               cyc_d = '0;
               if (bit_q == STOP_LAST) begin
                  // A pending byte starts straight away: no idle gap.
                  byte_done_c  = 1'b1;
                  byte_ready_c = 1'b1;
                  bit_d        = '0;
                  if (byte_valid_i) begin
                     state_d = TX_START;
                     data_d  = byte_data_i;
                  end else begin
                     state_d = TX_IDLE;
                  end
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               cyc_d = cyc_q + CNT_W'(1);
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   // Line level follows the current state one clock later, straight from a flop.
   always_comb begin
      txd_d = 1'b1;
      case (state_q)
         TX_START: txd_d = 1'b0;
         TX_DATA:  txd_d = data_q[bit_q];
         default:  txd_d = 1'b1;
      endcase
   end

   assign txd_o = txd_q;

endmodule

// File: rtl/uart_word_tx.sv
// uart_word_tx: sends 32-bit words as four 8N1 frames, least-significant byte first.
//   clk, resetn  : clock, async active-low reset
//   uart_tx_en   : gates acceptance of new words (a word in flight always completes)
//   word_valid   : word_data is valid
//   word_ready   : registered, a word is accepted on this edge if word_valid is high
//   word_data    : word to transmit, captured on accept
//   uart_txd     : serial line, idle high, registered
//   uart_tx_busy : a word is in flight
//   word_done    : one-cycle pulse when the last stop bit of byte 3 ends
module uart_word_tx
   import uart_word_tx_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 50000000,
   parameter int unsigned BIT_RATE  = 9600,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              uart_tx_en,
   input  logic              word_valid,
   output logic              word_ready,
   input  logic [WORD_W-1:0] word_data,
   output logic              uart_txd,
   output logic              uart_tx_busy,
   output logic              word_done
);

   localparam int unsigned      CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
   localparam int unsigned      IDX_W          = $clog2(BYTES_PER_WORD);
   localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(BYTES_PER_WORD - 1);

   word_state_e          state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [WORD_W-1:0]    word_q, word_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 ready_q, ready_d;

   logic                 accept_c;
   logic [IDX_W-1:0]     nxt_idx_c;
   logic                 byte_valid_c;
   logic [DATA_BITS-1:0] byte_data_c;
   logic                 byte_ready_c;
   logic                 byte_done_c;

   assign accept_c  = word_valid & ready_q;
   assign nxt_idx_c = idx_q + IDX_W'(1);

   // The first byte comes straight from word_data so it starts on the accept edge;
   // later bytes are offered while the previous one is still on the line.
   assign byte_valid_c = accept_c | (busy_q & (idx_q != IDX_LAST));
   assign byte_data_c  = accept_c ? word_data[DATA_BITS-1:0]
                                  : word_q[{nxt_idx_c, 3'b000} +: DATA_BITS];

   uart_tx_byte #(
      .CYCLES_PER_BIT (CYCLES_PER_BIT),
      .STOP_BITS      (STOP_BITS)
   ) u_tx_byte (
      .clk          (clk),
      .resetn       (resetn),
      .byte_valid_i (byte_valid_c),
      .byte_data_i  (byte_data_c),
      .byte_ready_c (byte_ready_c),
      .byte_done_c  (byte_done_c),
      .txd_o        (uart_txd)
   );

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= W_IDLE;
         idx_q   <= '0;
         word_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   // Word handshake and byte index sequencing.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      word_d  = word_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ready_d = 1'b0;
      case (state_q)
         W_IDLE: begin
            if (accept_c) begin
               state_d = W_SEND;
               word_d  = word_data;
               idx_d   = '0;
               busy_d  = 1'b1;
            end else begin
               ready_d = uart_tx_en;
            end
         end
         W_SEND: begin
            if (byte_valid_c && byte_ready_c) begin
               idx_d = nxt_idx_c;
            end
            if (byte_done_c && (idx_q == IDX_LAST)) begin
               state_d = W_IDLE;
               idx_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = W_IDLE;
      endcase
   end

   assign word_ready   = ready_q;
   assign uart_tx_busy = busy_q;
   assign word_done    = done_q;

endmodule
